// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, default widths and a parity helper.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam int DEF_DATA_WIDTH     = 8;
    localparam int DEF_PRESCALE_WIDTH = 16;
    localparam int MAX_DATA_WIDTH     = 9;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd4,
`endif
        STOP   = 3'd3
    } uart_state_t;

    // Zero-extended payload keeps one helper usable for every legal DATA_WIDTH.
    function automatic logic frame_parity(input logic [MAX_DATA_WIDTH-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// Valid/ready payload handshake between a byte producer and the UART transmitter.
interface uart_tx_param_if
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

    logic [DATA_WIDTH-1:0] data_in;
    logic                  valid;
    logic                  ready;

    modport master (output data_in, output valid, input ready);
    modport slave  (input data_in, input valid, output ready);

endinterface

// File: rtl/uart_tx_param_baud_cnt.sv
// Bit-period down-counter: bit_tick marks the last clk cycle of the current bit,
// tick_next is its next-cycle value so the caller can register edge-aligned pulses.
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int PRESCALE_WIDTH = DEF_PRESCALE_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      bit_tick,
    output logic                      tick_next
);

    logic [PRESCALE_WIDTH-1:0] cnt;
    logic [PRESCALE_WIDTH-1:0] cnt_next;
    logic [PRESCALE_WIDTH-1:0] period_m1;

    always_comb begin
        // A prescale of zero behaves as one cycle per bit.
        period_m1 = (prescale == '0) ? '0 : prescale - PRESCALE_WIDTH'(1);
        if (load)
            cnt_next = period_m1;
        else if (cnt != '0)
            cnt_next = cnt - PRESCALE_WIDTH'(1);
        else
            cnt_next = '0;
        tick_next = (cnt_next == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            bit_tick <= 1'b1;
        end else begin
            cnt      <= cnt_next;
            bit_tick <= tick_next;
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter with valid/ready intake and back-to-back framing.
// Optional parity is compiled in with the macro UART_TX_PARITY_EN.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int PRESCALE_WIDTH = DEF_PRESCALE_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    uart_tx_param_if.slave            stream,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic                      parity_en,
    input  logic                      parity_odd,
    input  logic                      two_stop,
    output logic                      tx,
    output logic                      busy,
    output logic                      done
);

    localparam int IDX_W = $clog2(DATA_WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    uart_state_t               state;
    logic [DATA_WIDTH-1:0]     data_r;
    logic [PRESCALE_WIDTH-1:0] prescale_r;
    logic [IDX_W-1:0]          bit_idx;
    logic                      stop_idx;
    logic                      two_stop_r;
    logic                      par_on;
    logic                      rdy;
    logic                      accept;
    logic                      stop_final;
    logic                      next_final_stop;
    logic                      load;
    logic                      bit_tick;
    logic                      tick_next;
    logic [PRESCALE_WIDTH-1:0] period_sel;

`ifdef UART_TX_PARITY_EN
    logic par_en_r;
    logic par_bit_r;
    assign par_on = par_en_r;
`else
    logic unused_parity;
    assign unused_parity = parity_en ^ parity_odd;
    assign par_on        = 1'b0;
`endif

    assign stop_final   = (stop_idx == two_stop_r);
    assign rdy          = (state == IDLE) || ((state == STOP) && bit_tick && stop_final);
    assign stream.ready = rdy;
    assign accept       = stream.valid && rdy;
    assign load         = accept || ((state != IDLE) && bit_tick);
    // A newly accepted frame times its start bit from the live prescale input.
    assign period_sel   = accept ? prescale : prescale_r;

    uart_baud_cnt #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) u_baud_cnt (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .prescale  (period_sel),
        .bit_tick  (bit_tick),
        .tick_next (tick_next)
    );

    // True when the coming cycle belongs to the final stop bit; combined with
    // tick_next it lets done be a register yet line up with that bit's last cycle.
    always_comb begin
        next_final_stop = 1'b0;
        case (state)
            DATA:    next_final_stop = bit_tick && (bit_idx == LAST_IDX) && !par_on && !two_stop_r;
`ifdef UART_TX_PARITY_EN
            PARITY:  next_final_stop = bit_tick && !two_stop_r;
`endif
            STOP:    next_final_stop = bit_tick ? !stop_final : stop_final;
            default: next_final_stop = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            data_r     <= stream.data_in;
            prescale_r <= prescale;
        end else if (bit_tick && ((state == START) || (state == DATA))) begin
            data_r <= data_r >> 1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            tx         <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            two_stop_r <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_r   <= 1'b0;
            par_bit_r  <= 1'b0;
`endif
        end else begin
            done <= next_final_stop && tick_next;
            if (accept) begin
                two_stop_r <= two_stop;
`ifdef UART_TX_PARITY_EN
                par_en_r   <= parity_en;
                par_bit_r  <= frame_parity(MAX_DATA_WIDTH'(stream.data_in), parity_odd);
`endif
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= START;
                        tx    <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (bit_tick) begin
                        state   <= DATA;
                        tx      <= data_r[0];
                        bit_idx <= '0;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        if (bit_idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                            if (par_en_r) begin
                                state <= PARITY;
                                tx    <= par_bit_r;
                            end else begin
                                state <= STOP;
                                tx    <= 1'b1;
                            end
`else
                            state <= STOP;
                            tx    <= 1'b1;
`endif
                            stop_idx <= 1'b0;
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                            tx      <= data_r[0];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_tick) begin
                        state    <= STOP;
                        tx       <= 1'b1;
                        stop_idx <= 1'b0;
                    end
                end
`endif
                STOP: begin
                    if (bit_tick) begin
                        if (!stop_final) begin
                            stop_idx <= 1'b1;
                        end else if (accept) begin
                            state <= START;
                            tx    <= 1'b0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving the data bits per frame (legal range 5..9).
REQ-002 SHALL have parameter PRESCALE_WIDTH, default 16, giving the width of the bit-period input.
REQ-003 SHALL have port clk, input, 1, the system clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port data_in, input, DATA_WIDTH, the frame payload, sent LSB first.
REQ-006 SHALL have port valid, input, 1, meaning the producer offers data_in.
REQ-007 SHALL have port ready, output, 1, meaning the block accepts data_in this cycle.
REQ-008 SHALL have port prescale, input, PRESCALE_WIDTH, giving clk cycles per bit (0 treated as 1).
REQ-009 SHALL have port parity_en, input, 1, which adds a parity bit after the data.
REQ-010 SHALL have port parity_odd, input, 1, selecting odd parity when 1 and even parity when 0.
REQ-011 SHALL have port two_stop, input, 1, selecting two stop bits when 1 and one when 0.
REQ-012 SHALL have port tx, output, 1, the serial line, which idles high.
REQ-013 SHALL have port busy, output, 1, high while a frame is in flight.
REQ-014 SHALL have port done, output, 1, a one-cycle pulse at the end of the final stop bit.

Function
REQ-015 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-016 SHALL accept a frame on a cycle with valid && ready, latching data_in, prescale, parity_en, parity_odd and two_stop; input changes mid-frame have no effect.
REQ-017 SHALL hold ready=1 in IDLE and in the last clk cycle of the final stop bit; ready SHALL be 0 at all other times.
REQ-018 SHALL drive the start bit (tx=0) starting the cycle after acceptance, giving a latency of 1 cycle.
REQ-019 SHALL hold each bit for exactly max(prescale,1) cycles using a bit-period counter that reloads at each bit boundary.
REQ-020 SHALL use these transitions: START->DATA after 1 bit; DATA->PARITY after DATA_WIDTH bits if parity is enabled, otherwise DATA->STOP; PARITY->STOP after 1 bit; STOP->IDLE after 1 or 2 bits.
REQ-021 SHALL compute the parity bit as XOR of the latched data, inverted when parity_odd=1.
REQ-022 SHALL drive tx=1 in IDLE and STOP.
REQ-023 SHALL, on acceptance in the final stop cycle, go directly from STOP to START with no idle bit between frames.
REQ-024 SHALL hold busy=1 in every state except IDLE.
REQ-025 SHALL pulse done for exactly one cycle, coincident with the final stop cycle, including back-to-back frames.
REQ-026 SHALL drive tx, busy and done from registers, with no combinational path from inputs to tx.

Reset
REQ-027 SHALL, while rst=0, force state=IDLE, tx=1, busy=0, done=0, ready=1 and clear all counters.
REQ-028 SHALL, on reset mid-frame, abandon the frame immediately, return tx to 1 asynchronously, and not pulse done.

Configuration
REQ-029 SHALL use the macro UART_TX_PARITY_EN; when it is defined, parity behaves per REQ-020 and REQ-021.
REQ-030 SHALL, when UART_TX_PARITY_EN is undefined, still have parity_en and parity_odd ports but ignore them, omit the PARITY state and parity logic, and always go DATA->STOP.

Structure
REQ-031 SHALL take the state encoding typedef (3-bit) and the default DATA_WIDTH/PRESCALE_WIDTH constants from shared package uart_pkg.
REQ-032 SHALL place the bit-period counter in sub-module uart_baud_cnt (inputs: load, prescale; output: bit_tick).

Verification
REQ-033 SHALL cover: DW=8, prescale=4, parity off, 1 stop, data 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1 each held 4 cycles, done at cycle 40 after acceptance.
REQ-034 SHALL cover: parity on, even, data 0x07 -> parity bit 1; same frame with odd -> parity bit 0; frame length 44 cycles at prescale=4.
REQ-035 SHALL cover: two_stop=1, prescale=2 -> tx high for 4 cycles after the last data bit, ready high only in the final cycle.
REQ-036 SHALL cover: valid held high for two frames 0x55, 0x0F -> second start bit on the cycle after the first done, two done pulses, no idle gap.
REQ-037 SHALL cover: prescale=0 -> each bit lasts 1 cycle; changing prescale mid-frame to 8 leaves the current frame unaffected.
REQ-038 SHALL cover: rst asserted during DATA bit 3 -> tx=1 and busy=0 immediately, no done pulse, and the next accepted frame is correct.
